// File: rtl/vdg_fetch_unit_if.sv
// Bus bundle between the VDG fetch unit, the arbiter's VDG port and the pixel/character consumer.
// master is the fetch unit side; slave is the arbiter/consumer side.
interface vdg_fetch_unit_if;
    logic        vdg_slot;
    logic        vsync;
    logic [7:0]  VDG_data_out;
    logic [15:0] VDG_address;
    logic        rd_en;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        frame_done;
    logic        underrun;

    modport master (
        input  vdg_slot, vsync, VDG_data_out, rd_en,
        output VDG_address, fifo_data, fifo_empty, frame_done, underrun
    );

    modport slave (
        output vdg_slot, vsync, VDG_data_out, rd_en,
        input  VDG_address, fifo_data, fifo_empty, frame_done, underrun
    );
endinterface

// File: rtl/vdg_fetch_unit.sv
// Sequential video-RAM reader feeding a byte FIFO, restarted by vsync.
// Optional sticky underrun detection is built when VDG_FETCH_UNDERRUN_EN is defined.
module vdg_fetch_unit #(
    parameter logic [15:0] BASE_ADDR   = 16'h4000,
    parameter int unsigned FRAME_BYTES = 512,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input logic              clk,
    input logic              reset_n,
    vdg_fetch_unit_if.master bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IssW = $clog2(FRAME_BYTES + 1);
    localparam logic [15:0] LastAddr = 16'(32'(BASE_ADDR) + FRAME_BYTES - 1);
    localparam logic [IssW-1:0] FrameBytes = IssW'(FRAME_BYTES);

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    logic [IssW-1:0] issued_q, issued_d;
    logic            v1_q, v1_d, v2_q, v2_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      head_q, head_d;
    logic            empty_q, empty_d;
    logic            done_q, done_d;
    logic [7:0]      mem [FIFO_DEPTH];

    logic            slot, push, pop, issue;
    logic [CntW:0]   occupancy;

    assign slot = bus.vdg_slot;
    assign pop  = bus.rd_en && !empty_q;
    assign push = slot && v2_q;

    // Buffered plus in-flight bytes must never exceed the FIFO capacity.
    assign occupancy = {1'b0, count_q} + (CntW + 1)'(v1_q) + (CntW + 1)'(v2_q);
    assign issue     = slot && (state_q == StFetch) && (issued_q != FrameBytes)
                       && (occupancy < (CntW + 1)'(FIFO_DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_d   = done_q;

        if (slot) begin
            v2_d = v1_q;
            v1_d = issue;
        end
        if (issue) begin
            addr_d   = (addr_q == LastAddr) ? BASE_ADDR : addr_q + 16'd1;
            issued_d = issued_q + 1'b1;
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CntW'(push) - CntW'(pop);

        unique case (state_q)
            StIdle: ;
            StFetch: begin
                if (issued_q == FrameBytes && !v1_q && !v2_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    addr_d  = BASE_ADDR;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase

        // vsync overrides everything, dropping buffered and in-flight bytes.
        if (bus.vsync) begin
            state_d  = StFetch;
            addr_d   = BASE_ADDR;
            issued_d = '0;
            v1_d     = 1'b0;
            v2_d     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            done_d   = 1'b0;
        end

        empty_d = (count_d == '0);
        // The new head is either the byte being written this edge or a stored entry.
        if (empty_d)                              head_d = head_q;
        else if (push && wr_ptr_q == rd_ptr_d)    head_d = bus.VDG_data_out;
        else                                      head_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            addr_q   <= BASE_ADDR;
            issued_q <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= 8'h00;
            empty_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.vsync) mem[wr_ptr_q] <= bus.VDG_data_out;
    end

`ifdef VDG_FETCH_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (!reset_n || bus.vsync) begin
            underrun_q <= 1'b0;
        end else if (bus.rd_en && empty_q && state_q == StFetch) begin
            underrun_q <= 1'b1;
        end
    end

    assign bus.underrun = underrun_q;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.VDG_address = addr_q;
    assign bus.fifo_data   = head_q;
    assign bus.fifo_empty  = empty_q;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_vdg_fetch_unit.sv
// Randomized bench for vdg_fetch_unit: arbiter bus model plus a frame-level reference model
// (expected address of the n-th issue, expected byte of the n-th pop).
module tb_vdg_fetch_unit;
    localparam logic [15:0] Base  = 16'h4000;
    localparam int          Frame = 512;
    localparam int          Depth = 16;
`ifdef VDG_FETCH_UNDERRUN_EN
    localparam logic UndExp = 1'b1;
`else
    localparam logic UndExp = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    vdg_fetch_unit_if bus();

    vdg_fetch_unit #(
        .BASE_ADDR  (Base),
        .FRAME_BYTES(Frame),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram(input logic [15:0] a);
        return a[7:0] ^ {a[3:0], a[15:12]} ^ 8'h3c;
    endfunction

    // Arbiter: samples the address at a slot edge, returns data for the previous slot's address.
    logic [15:0] arb_addr;
    always @(posedge clk) begin
        if (bus.vdg_slot) begin
            bus.VDG_data_out <= ram(arb_addr);
            arb_addr         <= bus.VDG_address;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int issued   = 0;
    int popped   = 0;
    bit active   = 0;
    bit und_seen = 0;
    int lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit slot, input bit rd, input bit vs, input bit rst_n);
        logic [15:0] pa;
        logic        pe;
        logic [7:0]  pd;
        bus.vdg_slot = slot;
        bus.rd_en    = rd;
        bus.vsync    = vs;
        reset_n      = rst_n;
        pa = bus.VDG_address;
        pe = bus.fifo_empty;
        pd = bus.fifo_data;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            active = 0; issued = 0; popped = 0; und_seen = 0;
            check("rst_addr", 32'(bus.VDG_address), 32'(Base));
            check("rst_data", 32'(bus.fifo_data), 32'h0);
            check("rst_empty", 32'(bus.fifo_empty), 32'h1);
            check("rst_done", 32'(bus.frame_done), 32'h0);
            check("rst_und", 32'(bus.underrun), 32'h0);
        end else if (vs) begin
            active = 1; issued = 0; popped = 0; und_seen = 0;
            check("vs_addr", 32'(bus.VDG_address), 32'(Base));
            check("vs_empty", 32'(bus.fifo_empty), 32'h1);
            check("vs_done", 32'(bus.frame_done), 32'h0);
            check("vs_und", 32'(bus.underrun), 32'h0);
        end else begin
            if (!active) begin
                check("idle_addr", 32'(bus.VDG_address), 32'(Base));
                check("idle_empty", 32'(bus.fifo_empty), 32'h1);
            end else if (slot && bus.VDG_address != pa) begin
                check("issue_addr", 32'(pa), 32'(16'(Base + issued % Frame)));
                issued++;
                check("issue_limit", 32'(issued <= Frame), 32'h1);
                check("throttle", 32'(issued - popped <= Depth), 32'h1);
            end
            if (!slot) check("addr_hold", 32'(bus.VDG_address), 32'(pa));
            if (rd && !pe) begin
                check("pop_data", 32'(pd), 32'(ram(16'(Base + popped))));
                popped++;
            end
`ifdef VDG_FETCH_UNDERRUN_EN
            if (und_seen) check("und_sticky", 32'(bus.underrun), 32'h1);
            und_seen = bus.underrun;
`else
            check("und_off", 32'(bus.underrun), 32'h0);
`endif
        end
    endtask

    initial begin
        bus.vdg_slot = 0;
        bus.rd_en    = 0;
        bus.vsync    = 0;
        reset_n      = 0;

        // Reset, then idle with slots: nothing may be issued.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(i[0], 1'($urandom_range(0, 1)), 0, 1);

        // First-byte latency with a slot every other cycle, no pops.
        cycle(0, 0, 1, 1);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle(c % 2 == 0, 0, 0, 1);
            if (!bus.fifo_empty && lat == 0) lat = c;
        end
        check("first_byte_lat", 32'(lat), 32'd6);

        // Stall once FIFO plus in-flight reads fill the buffer.
        for (int i = 0; i < 60; i++) cycle(1, 0, 0, 1);
        check("stall_issued", 32'(issued), 32'(Depth));
        check("stall_addr", 32'(bus.VDG_address), 32'h4010);
        check("stall_nonempty", 32'(bus.fifo_empty), 32'h0);
        cycle(0, 1, 0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 0, 0, 1);
        check("one_more_issued", 32'(issued), 32'(Depth + 1));
        check("one_more_addr", 32'(bus.VDG_address), 32'h4011);

        // Finish the frame with random slots and pops.
        for (int i = 0; i < 20000 && !(bus.frame_done && bus.fifo_empty); i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0, 1);
        check("frame_popped", 32'(popped), 32'(Frame));
        check("frame_done", 32'(bus.frame_done), 32'h1);
        check("frame_addr", 32'(bus.VDG_address), 32'(Base));
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 1);
        check("done_no_issue", 32'(issued), 32'(Frame));
        check("done_held", 32'(bus.frame_done), 32'h1);

        // vsync mid-frame with reads in flight: stale bytes must never be popped.
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 2000 && bus.VDG_address != 16'h40a3; i++) cycle(1, 1, 0, 1);
        check("reach_40a3", 32'(bus.VDG_address), 32'h40a3);
        cycle(1, 1, 1, 1);
        for (int i = 0; i < 30; i++) cycle(1, 1, 0, 1);
        check("restart_pops", 32'(popped > 0), 32'h1);

        // Reset mid-frame, then idle until the next vsync.
        for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 30; i++) cycle(i[0], 1'($urandom_range(0, 1)), 0, 1);

        // Underrun: pop request while empty in FETCH.
        cycle(0, 0, 1, 1);
        cycle(0, 1, 0, 1);
        check("und_set", 32'(bus.underrun), 32'(UndExp));
        for (int i = 0; i < 5; i++) cycle(i[0], 0, 0, 1);
        check("und_hold", 32'(bus.underrun), 32'(UndExp));
        cycle(0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vdg_fetch_unit.md
# vdg_fetch_unit

Display-memory reader on the VDG side of the two-phase system bus arbiter. Issues sequential video-RAM addresses on the arbiter's VDG address input, captures the returned bytes from the arbiter's VDG data output, and buffers them in a small FIFO. The VDG pixel/character logic pops bytes at its own rate. Restarts at the top of video RAM on every vertical sync.

## Interface
Parameters:
- BASE_ADDR, 16'h4000, first video-RAM address of a frame
- FRAME_BYTES, 512, bytes fetched per frame (1..4096)
- FIFO_DEPTH, 16, buffer entries (power of two, >= 4)

Ports:
- clk  in  1  system clock, same clock as the arbiter
- reset_n  in  1  synchronous, active-low reset
- vdg_slot  in  1  high in the cycle whose closing clk edge is an arbiter VDG-phase edge
- vsync  in  1  one-cycle frame-start pulse
- VDG_data_out  in  8  byte returned by the arbiter
- VDG_address  out  16  address presented to the arbiter
- rd_en  in  1  consumer pop request
- fifo_data  out  8  head-of-FIFO byte, valid while fifo_empty=0
- fifo_empty  out  1  FIFO has no entries
- frame_done  out  1  all FRAME_BYTES issued and captured for this frame
- underrun  out  1  sticky underrun flag (see Configuration)

## Operation
- Slot edge: a rising clk edge with vdg_slot=1.
- Bus protocol: the arbiter samples VDG_address at slot edge K. It also loads VDG_data_out with RAM data for the address it sampled at slot edge K-1. The byte for the address issued at slot edge K is therefore captured at slot edge K+2. This gives a fixed 2-slot return latency and at most 2 reads in flight, tracked by a 2-stage valid shift (v1, v2) that advances on slot edges.
- State machine:
  - IDLE: entered after reset. VDG_address=BASE_ADDR, no issues. vsync moves to FETCH.
  - FETCH: at each slot edge, issue if fifo_count + inflight < FIFO_DEPTH. Issuing sets v1 and advances VDG_address to the next address; a non-issuing slot shifts in v1=0. When the last of FRAME_BYTES has been issued and v1=v2=0, go to DONE.
  - DONE: frame_done=1, VDG_address holds BASE_ADDR, no issues. vsync moves to FETCH.
- Capture: at a slot edge with v2=1, push VDG_data_out into the FIFO.
- Address arithmetic: 16-bit. The next address after BASE_ADDR+FRAME_BYTES-1 wraps to BASE_ADDR. No carry beyond bit 15.
- vsync in any state except during reset:
  - empty the FIFO and clear v1/v2, discarding in-flight data
  - set VDG_address=BASE_ADDR, clear frame_done, enter FETCH
  - issue starts at the first slot edge after vsync
- Pop: rd_en=1 and fifo_empty=0 removes the head; fifo_data shows the next entry from the following cycle. rd_en while empty is ignored.
- Simultaneous push and pop: count is unchanged and both take effect. A push with FIFO full cannot occur because of the throttle rule.
- Simultaneous vsync and rd_en or push: vsync wins, and the FIFO is empty afterwards.

## Timing
- Reset values: VDG_address=BASE_ADDR, fifo_data=8'h00, fifo_empty=1, frame_done=0, underrun=0, state IDLE, v1=v2=0, FIFO count 0.
- Reset takes effect at any clk edge with reset_n=0, including mid-frame. In-flight data is dropped.
- All outputs are registered.
- First byte after vsync:
  - fifo_empty falls one clk after the third slot edge following vsync (issue edge plus 2 slots).
  - With vdg_slot every other cycle, that is 6 clk cycles after the vsync edge.
- Sustained throughput: 1 byte per slot while not throttled.
- The fifo_empty/fifo_data update is visible the cycle after the push or pop edge.

## Configuration
- Macro VDG_FETCH_UNDERRUN_EN.
- Defined: underrun goes to 1 on any clk edge with rd_en=1 and fifo_empty=1 while state is FETCH. It stays set until vsync or reset.
- Undefined: underrun is tied to 0 and no detection logic is built.

## Test plan
- Reset then vsync with vdg_slot toggling: VDG_address sequence 4000, 4001, 4002, ... one per slot edge. fifo_empty=0 six cycles after vsync. Popped bytes equal the model RAM contents at those addresses.
- Consumer never pops, FIFO_DEPTH=16: exactly 16 addresses issued (4000–400F). Issue stalls with VDG_address at 4010 and fifo_empty=0. After one pop, exactly one further address is issued.
- Full frame FRAME_BYTES=512 with continuous pops: 512 bytes popped, last from 41FF. frame_done=1 afterwards, VDG_address=4000, no further issues until vsync.
- vsync asserted mid-frame at address 40A3 with 2 reads in flight: FIFO empty the next cycle, stale bytes never appear, next issued address is 4000.
- reset_n=0 for one cycle mid-frame: all outputs return to reset values and state is IDLE. No issues occur until vsync.
- With VDG_FETCH_UNDERRUN_EN, rd_en pulsed while empty in FETCH: underrun=1 and held until the next vsync. Without the macro, underrun stays 0.
